golden_nonce_tx: RTL and testbench
==================================

// Module: golden_nonce_tx
// PURPOSE
//  Transmit-side counterpart of the serial work receiver: queues golden nonces from the hasher control unit
//  and sends each one to the host as 4 UART 8N1 bytes on TxD. Replaces the drop-if-busy single-word sender.
//  Nonces found back-to-back are buffered, and any nonce lost to overflow is counted.
//  Sits in fpgaminer_top on hash_clk, fed by the is_golden_ticket / golden_nonce logic.
// PARAMETERS
//  CLKS_PER_BIT   434  hash_clk cycles per UART bit (50 MHz / 115200); legal range >= 2
//  FIFO_LOG2      2    log2 of nonce FIFO depth (default depth 4 words)
// PORTS
//  clk           in   1   hash_clk; all logic on rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  nonce_valid   in   1   1-cycle strobe: nonce is a golden nonce to queue
//  nonce         in   32  golden nonce, already offset-corrected
//  TxD           out  1   UART line, idle high
//  busy          out  1   high while a word is being transmitted or the FIFO is non-empty
//  fifo_full     out  1   high when FIFO holds 2**FIFO_LOG2 words
//  drop_count    out  8   saturating count of nonces dropped due to full FIFO
// BEHAVIOUR
//  Reset (async, reset_n=0): TxD=1, busy=0, fifo_full=0, drop_count=0, FIFO emptied, FSM=IDLE, counters=0.
//   Reset asserted mid-frame aborts the frame immediately; TxD returns high in the same reset assertion.
//  FIFO: circular, FIFO_LOG2+1-bit wr/rd pointers (wrap bit distinguishes full from empty).
//   Push on nonce_valid when !fifo_full, or when full and a pop occurs in the same cycle.
//   nonce_valid while full and no pop: word discarded, drop_count += 1, saturates at 255 (no wrap).
//   Push+pop in the same cycle: occupancy unchanged, both pointers advance.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE: if FIFO non-empty -> pop head into 32-bit shift reg, byte_idx=0, go to START.
//   START: TxD=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//   DATA: TxD = current byte bit bit_idx (LSB first), CLKS_PER_BIT cycles each; after bit 7 -> STOP.
//   STOP: TxD=1 for CLKS_PER_BIT cycles; then byte_idx==3 ? IDLE : (byte_idx+1, START).
//   Byte order: nonce[7:0] first, nonce[31:24] last (little-endian, as the host parses it).
//   Word = 40 bit-times = 40*CLKS_PER_BIT cycles; consecutive bytes/words have no extra idle gap,
//   except the single IDLE cycle between words.
//  Baud counter: counts 0..CLKS_PER_BIT-1, reset to 0 on every state/bit change; no drift across a word.
//  Latency: nonce_valid in cycle N with FSM idle and FIFO empty -> FIFO written at edge N,
//   popped at edge N+1, TxD falls (start bit) in cycle N+2.
//  busy = (FSM != IDLE) | FIFO non-empty; registered outputs, TxD driven from a flop (glitch-free).
//  nonce_valid is accepted in any FSM state; transmission of the current word is never disturbed.
// TESTING (sim with CLKS_PER_BIT=4, FIFO_LOG2=2)
//  1 Single word: nonce=32'h12345678 strobe -> TxD start bit 2 cycles later; bytes 78,56,34,12 LSB-first,
//    each framed 0/data/1; 160 cycles total; busy falls after final stop bit.
//  2 Burst: 4 strobes on consecutive cycles (A0000001..A0000004) -> all 4 sent in order, fifo_full seen,
//    drop_count=0.
//  3 Overflow: 6 consecutive strobes while idle -> 1 word popped + 4 queued; 6th dropped;
//    drop_count=1; 5 words sent.
//  4 Saturation: 300 strobes while full -> drop_count holds at 255.
//  5 Push+pop same cycle: FIFO full, strobe on the IDLE pop cycle -> accepted, drop_count unchanged.
//  6 Reset mid-frame: assert reset_n=0 during DATA of byte 2 -> TxD=1, busy=0 immediately;
//    after release, the next strobe sends a clean full word.

Source files
------------

// File: rtl/golden_nonce_tx.sv
// ============================================================================
// golden_nonce_tx : FIFO-buffered golden-nonce sender, 4 UART 8N1 bytes/word
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module golden_nonce_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_LOG2    = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        nonce_valid,
   input  logic [31:0] nonce,
   output logic        TxD,
   output logic        busy,
   output logic        fifo_full,
   output logic [7:0]  drop_count
);

   localparam int DEPTH  = 1 << FIFO_LOG2;
   localparam int PW     = FIFO_LOG2 + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0]     FULL_XOR  = {1'b1, {(PW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state, state_n;
   logic [BAUD_W-1:0]   baud, baud_n;
   logic [2:0]          bit_idx, bit_n;
   logic [1:0]          byte_idx, byte_n;
   logic [31:0]         word, word_n;
   logic                tx_n;

   logic [31:0]         mem [DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic                empty, full, pop, push, drop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push  = nonce_valid && (!full || pop);
   assign drop  = nonce_valid && !push;
   assign wr_ptr_n = wr_ptr + PW'(push);
   assign rd_ptr_n = rd_ptr + PW'(pop);

   always_comb begin
      state_n = state;
      baud_n  = baud + BAUD_W'(1);
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      word_n  = word;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            baud_n = '0;
            if (!empty) begin
               pop     = 1'b1;
               word_n  = mem[rd_ptr[PW-2:0]];
               byte_n  = 2'd0;
               state_n = START;
            end
         end
         START: begin
            if (baud == BAUD_LAST) begin
               baud_n  = '0;
               bit_n   = 3'd0;
               state_n = DATA;
            end
         end
         DATA: begin
            if (baud == BAUD_LAST) begin
               baud_n = '0;
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_n   = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (baud == BAUD_LAST) begin
               baud_n = '0;
               if (byte_idx == 2'd3) begin
                  state_n = IDLE;
               end else begin
                  byte_n  = byte_idx + 2'd1;
                  state_n = START;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // Line level follows the next state so TxD changes on the same edge as the FSM.
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = word_n[{byte_n, bit_n}];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         baud       <= '0;
         bit_idx    <= 3'd0;
         byte_idx   <= 2'd0;
         word       <= 32'd0;
         TxD        <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         busy       <= 1'b0;
         fifo_full  <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         state     <= state_n;
         baud      <= baud_n;
         bit_idx   <= bit_n;
         byte_idx  <= byte_n;
         word      <= word_n;
         TxD       <= tx_n;
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         busy      <= (state_n != IDLE) || (wr_ptr_n != rd_ptr_n);
         fifo_full <= ((wr_ptr_n ^ rd_ptr_n) == FULL_XOR);
         if (drop && (drop_count != 8'hFF))
            drop_count <= drop_count + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[PW-2:0]] <= nonce;
   end

endmodule

`default_nettype wire

// File: tb/tb_golden_nonce_tx.sv
// ============================================================================
// tb_golden_nonce_tx : directed bench with UART decoder and nonce scoreboard
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_golden_nonce_tx;

   localparam int C = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        nonce_valid = 1'b0;
   logic [31:0] nonce = 32'd0;
   logic        TxD, busy, fifo_full;
   logic [7:0]  drop_count;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   golden_nonce_tx #(.CLKS_PER_BIT(C), .FIFO_LOG2(2)) dut (
      .clk(clk), .reset_n(reset_n), .nonce_valid(nonce_valid), .nonce(nonce),
      .TxD(TxD), .busy(busy), .fifo_full(fifo_full), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // UART decoder: samples the first cycle of every bit, rebuilds words, pops the scoreboard
   bit          mon_active = 1'b0;
   int          mon_cnt = 0, mon_gap = 0, mon_nbytes = 0;
   logic [7:0]  mon_byte = 8'd0;
   logic [31:0] mon_word = 32'd0, mon_exp;

   always @(negedge clk) begin
      if (!reset_n) begin
         mon_active = 1'b0;
         mon_nbytes = 0;
         mon_gap    = 0;
      end else if (!mon_active) begin
         mon_gap++;
         if (TxD === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            if (mon_nbytes != 0) begin
               checks++;
               assert (mon_gap === C) else begin
                  failures++;
                  $error("FAIL byte_gap observed=%0d expected=%0d", mon_gap, C);
               end
            end
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % C == 0) begin
            if (mon_cnt < 9*C) begin
               mon_byte[3'(mon_cnt/C - 1)] = TxD;
            end else begin
               checks++;
               assert (TxD === 1'b1) else begin
                  failures++;
                  $error("FAIL stop_bit observed=%b expected=1", TxD);
               end
               mon_word[mon_nbytes*8 +: 8] = mon_byte;
               mon_nbytes++;
               mon_active = 1'b0;
               mon_gap    = 0;
               if (mon_nbytes == 4) begin
                  mon_nbytes = 0;
                  checks++;
                  assert (exp_q.size() != 0) else begin
                     failures++;
                     $error("FAIL unexpected_word observed=%h expected=none", mon_word);
                  end
                  if (exp_q.size() != 0) begin
                     mon_exp = exp_q.pop_front();
                     checks++;
                     assert (mon_word === mon_exp) else begin
                        failures++;
                        $error("FAIL word observed=%h expected=%h", mon_word, mon_exp);
                     end
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] v, input bit accepted);
      @(negedge clk);
      nonce_valid = 1'b1;
      nonce       = v;
      if (accepted) exp_q.push_back(v);
   endtask

   task automatic release_valid();
      @(negedge clk);
      nonce_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n, first_low;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_txd", 32'(TxD), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_full", 32'(fifo_full), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      reset_n = 1'b1;

      // single word: latency and total busy time
      send(32'h12345678, 1'b1);
      n = 0;
      first_low = -1;
      do begin
         @(negedge clk);
         if (n == 0) nonce_valid = 1'b0;
         n++;
         if (TxD === 1'b0 && first_low < 0) first_low = n;
      end while (busy === 1'b1 && n < 400);
      chk("start_latency", 32'(first_low), 32'd2);
      chk("busy_cycles", 32'(n), 32'd162);
      chk("t1_drained", 32'(exp_q.size()), 32'd0);

      // burst of 4 queued behind a word in flight
      send(32'hB0000000, 1'b1);
      release_valid();
      repeat (8) @(negedge clk);
      for (int i = 1; i <= 4; i++) send(32'hA0000000 + 32'(i), 1'b1);
      release_valid();
      chk("burst_full", 32'(fifo_full), 32'd1);
      chk("burst_drop", 32'(drop_count), 32'd0);
      wait_idle("burst", 5*161 + 50);
      chk("burst_drop_end", 32'(drop_count), 32'd0);

      // overflow: 6 strobes from idle, last one dropped
      for (int i = 0; i < 6; i++) send(32'h50000000 + 32'(i), i < 5);
      release_valid();
      chk("ovf_full", 32'(fifo_full), 32'd1);
      chk("ovf_drop", 32'(drop_count), 32'd1);
      wait_idle("ovf", 5*161 + 50);
      chk("ovf_full_end", 32'(fifo_full), 32'd0);

      // push+pop on the IDLE pop cycle with the FIFO full
      for (int i = 0; i < 5; i++) send(32'hD0000000 + 32'(i), 1'b1);
      release_valid();
      repeat (156) @(negedge clk);
      chk("pp_full_before", 32'(fifo_full), 32'd1);
      send(32'hD0000005, 1'b1);
      release_valid();
      chk("pp_full_after", 32'(fifo_full), 32'd1);
      chk("pp_drop", 32'(drop_count), 32'd1);
      wait_idle("pp", 6*161 + 50);

      // saturation: 300 strobes, only fill and the pop-cycle strobe accepted
      for (int i = 0; i < 300; i++) send(32'hC0000000 + 32'(i), (i < 5) || (i == 162));
      release_valid();
      chk("sat_drop", 32'(drop_count), 32'd255);
      wait_idle("sat", 6*161 + 50);
      chk("sat_drop_end", 32'(drop_count), 32'd255);

      // reset during data bits of the second byte
      send(32'hE0000000, 1'b1);
      release_valid();
      repeat (48) @(negedge clk);
      chk("pre_rst_txd", 32'(TxD), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_txd", 32'(TxD), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_drop", 32'(drop_count), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      send(32'hF0F0A55A, 1'b1);
      release_valid();
      wait_idle("post_rst", 250);
      chk("post_rst_drop", 32'(drop_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
